// File: rtl/aes_ctrl_pkg.sv
// Shared constants for the cipher control front-end: FSM encoding, register bit
// positions, lock-bit indices and word-offset helpers for the register map.
package aes_ctrl_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ZEROIZE = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_CLR     = 3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_BAD_SEL = 3;

  localparam int LK_CTRL_WR = 0;
  localparam int LK_STAT_RD = 1;
  localparam int LK_PT_RD   = 2;
  localparam int LK_DATA_WR = 3;
  localparam int LK_CT_RD   = 4;
  localparam int LK_KEY_WR  = 5;
  localparam int LK_IRQ     = 6;

  localparam int W_CTRL   = 0;
  localparam int W_STATUS = 1;
  localparam int W_PT     = 4;

  function automatic int w_state(int blk);
    return W_PT + blk;
  endfunction

  function automatic int w_ct(int blk);
    return W_PT + 2 * blk;
  endfunction

  function automatic int w_key_sel(int blk);
    return W_PT + 3 * blk;
  endfunction

  function automatic int w_key(int blk);
    return W_PT + 3 * blk + 1;
  endfunction

endpackage

// File: rtl/aes_ctrl_keybank.sv
// Key slot storage: word-addressed write port, bulk zeroize, and a registered
// snapshot of one slot presented to the engine (word 0 in the MSBs).
module aes_ctrl_keybank
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_KEYS  = 3,
  parameter int KEY_WORDS = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_en,
  input  logic [31:0]             wr_off,
  input  logic [31:0]             wr_data,
  input  logic                    zeroize,
  input  logic                    snap_en,
  input  logic [1:0]              snap_sel,
  output logic [32*KEY_WORDS-1:0] key_o
);

  localparam int N = NUM_KEYS * KEY_WORDS;

  logic [31:0] mem_q [N];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || zeroize) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
      key_o <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_en && wr_off == 32'(i)) mem_q[i] <= wr_data;
      end
      if (snap_en) begin
        for (int k = 0; k < NUM_KEYS; k++) begin
          for (int j = 0; j < KEY_WORDS; j++) begin
            if (snap_sel == 2'(k)) key_o[32*(KEY_WORDS-1-j) +: 32] <= mem_q[k*KEY_WORDS+j];
          end
        end
      end
    end
  end

endmodule

// File: rtl/aes_ctrl_regif.sv
// Register front-end for the block-cipher engine: decode, lock gating, start/valid
// handshake with timeout. States: IDLE | waiting for start; RUN | engine busy, timeout armed.
module aes_ctrl_regif
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_KEYS    = 3,
  parameter int KEY_WORDS   = 6,
  parameter int BLK_WORDS   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [7:0]              reglk_ctrl_i,
  input  logic [31:0]             bus_addr_i,
  input  logic                    bus_write_i,
  input  logic [31:0]             bus_wdata_i,
  input  logic                    bus_valid_i,
  output logic [31:0]             bus_rdata_o,
  output logic                    bus_ready_o,
  output logic                    bus_error_o,
  output logic                    eng_start_o,
  output logic [32*BLK_WORDS-1:0] eng_pt_o,
  output logic [32*BLK_WORDS-1:0] eng_state_o,
  output logic [32*KEY_WORDS-1:0] eng_key_o,
  input  logic [32*BLK_WORDS-1:0] eng_ct_i,
  input  logic                    eng_valid_i,
  output logic                    irq_o
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [31:0] A_CTRL  = 32'(W_CTRL);
  localparam logic [31:0] A_STAT  = 32'(W_STATUS);
  localparam logic [31:0] A_PT    = 32'(W_PT);
  localparam logic [31:0] A_ST    = 32'(w_state(BLK_WORDS));
  localparam logic [31:0] A_CT    = 32'(w_ct(BLK_WORDS));
  localparam logic [31:0] A_KSEL  = 32'(w_key_sel(BLK_WORDS));
  localparam logic [31:0] A_KEY   = 32'(w_key(BLK_WORDS));
  localparam logic [31:0] A_KEND  = 32'(w_key(BLK_WORDS) + NUM_KEYS * KEY_WORDS);

  logic [31:0]   widx, key_off, stat, key_sel_q;
  logic [31:0]   pt_q [BLK_WORDS];
  logic [31:0]   st_q [BLK_WORDS];
  logic [31:0]   ct_q [BLK_WORDS];
  logic [0:0]    state_q;
  logic [TW-1:0] cnt_q;
  logic done_q, timeout_q, bad_sel_q, irq_en_q;
  logic done_d, timeout_d, bad_sel_d, irq_en_d;
  logic wr, is_ctrl, is_stat, in_pt, in_st, in_ct, is_ksel, in_key, mapped;
  logic locked, busy, busy_rej, wr_err, wr_ok, ctrl_wr, go, bad_start, zeroize;
  logic unused_bits;

  assign widx    = {24'd0, bus_addr_i[9:2]};
  assign key_off = widx - A_KEY;
  assign is_ctrl = widx == A_CTRL;
  assign is_stat = widx == A_STAT;
  assign in_pt   = widx >= A_PT && widx < A_ST;
  assign in_st   = widx >= A_ST && widx < A_CT;
  assign in_ct   = widx >= A_CT && widx < A_KSEL;
  assign is_ksel = widx == A_KSEL;
  assign in_key  = widx >= A_KEY && widx < A_KEND;
  assign mapped  = is_ctrl | is_stat | in_pt | in_st | in_ct | is_ksel | in_key;
  assign busy    = state_q == ST_RUN;

  // every CTRL write carries irq_en, so the irq-mask lock gates the whole CTRL word
  assign locked  = (is_ctrl & (reglk_ctrl_i[LK_CTRL_WR] | reglk_ctrl_i[LK_IRQ]))
                 | ((in_pt | in_st) & reglk_ctrl_i[LK_DATA_WR])
                 | ((in_key | is_ksel) & reglk_ctrl_i[LK_KEY_WR]);
  assign busy_rej = busy & ((in_pt | in_st | in_key | is_ksel)
                 | (is_ctrl & (bus_wdata_i[CTRL_START] | bus_wdata_i[CTRL_ZEROIZE])));

  assign wr          = bus_valid_i & bus_write_i;
  assign wr_err      = wr & (~mapped | is_stat | in_ct | locked | busy_rej);
  assign wr_ok       = wr & ~wr_err;
  assign bus_error_o = wr_err;
  assign bus_ready_o = 1'b1;

  assign ctrl_wr   = wr_ok & is_ctrl;
  assign zeroize   = ctrl_wr & bus_wdata_i[CTRL_ZEROIZE];
  assign go        = ctrl_wr & bus_wdata_i[CTRL_START] & ~bus_wdata_i[CTRL_ZEROIZE]
                   & ~busy & (key_sel_q < 32'(NUM_KEYS));
  assign bad_start = ctrl_wr & bus_wdata_i[CTRL_START] & ~bus_wdata_i[CTRL_ZEROIZE]
                   & (key_sel_q >= 32'(NUM_KEYS));

  assign unused_bits = ^{reglk_ctrl_i[7], bus_addr_i[31:10], bus_addr_i[1:0]};

  always_comb begin
    stat               = '0;
    stat[STAT_BUSY]    = busy;
    stat[STAT_DONE]    = done_q;
    stat[STAT_TIMEOUT] = timeout_q;
    stat[STAT_BAD_SEL] = bad_sel_q;
    bus_rdata_o        = '0;
    if (bus_valid_i && !bus_write_i) begin
      if (is_stat && !reglk_ctrl_i[LK_STAT_RD]) bus_rdata_o = stat;
      if (is_ksel) bus_rdata_o = key_sel_q;
      for (int i = 0; i < BLK_WORDS; i++) begin
        if (widx == A_PT + 32'(i) && !reglk_ctrl_i[LK_PT_RD]) bus_rdata_o = pt_q[i];
        if (widx == A_ST + 32'(i)) bus_rdata_o = st_q[i];
        if (widx == A_CT + 32'(i) && !reglk_ctrl_i[LK_CT_RD]) bus_rdata_o = ct_q[i];
      end
    end
  end

  // a completion on the same edge as a status clear must survive it
  always_comb begin
    done_d    = done_q;
    timeout_d = timeout_q;
    bad_sel_d = bad_sel_q;
    irq_en_d  = irq_en_q;
    if (ctrl_wr) irq_en_d = bus_wdata_i[CTRL_IRQ_EN];
    if (ctrl_wr && bus_wdata_i[CTRL_CLR]) begin
      done_d    = 1'b0;
      timeout_d = 1'b0;
      bad_sel_d = 1'b0;
    end
    if (busy) begin
      if (eng_valid_i) done_d = 1'b1;
      else if (cnt_q == '0) timeout_d = 1'b1;
    end
    if (go) begin
      done_d    = 1'b0;
      timeout_d = 1'b0;
      bad_sel_d = 1'b0;
    end
    if (bad_start) bad_sel_d = 1'b1;
  end

  always_comb begin
    eng_pt_o    = '0;
    eng_state_o = '0;
    for (int i = 0; i < BLK_WORDS; i++) begin
      eng_pt_o[32*(BLK_WORDS-1-i) +: 32]    = pt_q[i];
      eng_state_o[32*(BLK_WORDS-1-i) +: 32] = st_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      eng_start_o <= 1'b0;
      irq_o       <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      bad_sel_q   <= 1'b0;
      irq_en_q    <= 1'b0;
      key_sel_q   <= '0;
      for (int i = 0; i < BLK_WORDS; i++) begin
        pt_q[i] <= '0;
        st_q[i] <= '0;
        ct_q[i] <= '0;
      end
    end else begin
      eng_start_o <= go;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      bad_sel_q   <= bad_sel_d;
      irq_en_q    <= irq_en_d;
      irq_o       <= irq_en_d & (done_d | timeout_d);
      if (wr_ok && is_ksel) key_sel_q <= bus_wdata_i;
      for (int i = 0; i < BLK_WORDS; i++) begin
        if (wr_ok && widx == A_PT + 32'(i)) pt_q[i] <= bus_wdata_i;
        if (wr_ok && widx == A_ST + 32'(i)) st_q[i] <= bus_wdata_i;
      end
      if (state_q == ST_IDLE) begin
        if (go) begin
          state_q <= ST_RUN;
          cnt_q   <= TW'(TIMEOUT_CYC - 1);
        end
      end else if (eng_valid_i) begin
        state_q <= ST_IDLE;
        for (int i = 0; i < BLK_WORDS; i++) ct_q[i] <= eng_ct_i[32*(BLK_WORDS-1-i) +: 32];
      end else if (cnt_q == '0) begin
        state_q <= ST_IDLE;
      end else begin
        cnt_q <= cnt_q - TW'(1);
      end
    end
  end

  aes_ctrl_keybank #(
    .NUM_KEYS  (NUM_KEYS),
    .KEY_WORDS (KEY_WORDS)
  ) u_keybank (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wr_en    (wr_ok & in_key),
    .wr_off   (key_off),
    .wr_data  (bus_wdata_i),
    .zeroize  (zeroize),
    .snap_en  (go),
    .snap_sel (key_sel_q[1:0]),
    .key_o    (eng_key_o)
  );

endmodule

// File: tb/tb_aes_ctrl_regif.sv
// Scoreboard bench for aes_ctrl_regif: a register-level model predicts every bus
// response and engine start; a negedge monitor compares DUT outputs against it.
module tb_aes_ctrl_regif;

  localparam int NK = 3, KW = 6, BW = 4, TO = 16;
  localparam int P = 4 + BW, A_CT = P + BW, A_KS = P + 2*BW, A_KEY = A_KS + 1;
  localparam int A_END = A_KEY + NK*KW;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] reglk = '0;
  logic [31:0] bus_addr = '0, bus_wdata = '0, bus_rdata;
  logic bus_write = 1'b0, bus_valid = 1'b0, bus_ready, bus_error;
  logic eng_start, eng_valid = 1'b0, irq;
  logic [32*BW-1:0] eng_pt, eng_state, eng_ct = '0;
  logic [32*KW-1:0] eng_key;

  always #5 clk = ~clk;

  aes_ctrl_regif #(.NUM_KEYS(NK), .KEY_WORDS(KW), .BLK_WORDS(BW), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .reglk_ctrl_i(reglk), .bus_addr_i(bus_addr),
    .bus_write_i(bus_write), .bus_wdata_i(bus_wdata), .bus_valid_i(bus_valid),
    .bus_rdata_o(bus_rdata), .bus_ready_o(bus_ready), .bus_error_o(bus_error),
    .eng_start_o(eng_start), .eng_pt_o(eng_pt), .eng_state_o(eng_state),
    .eng_key_o(eng_key), .eng_ct_i(eng_ct), .eng_valid_i(eng_valid), .irq_o(irq));

  typedef struct { logic [31:0] rd; bit er; int a; } resp_t;
  typedef struct { logic [32*KW-1:0] key; logic [32*BW-1:0] pt; logic [32*BW-1:0] st; } start_t;
  resp_t  resp_q[$];
  start_t start_q[$];

  int checks = 0, failures = 0;
  bit mon_on = 1'b0;

  logic [31:0] m_pt [BW], m_st [BW], m_ct [BW], m_key [NK][KW], m_ksel;
  bit m_irq_en, m_done, m_to, m_bad, m_busy, m_irq;
  int m_runcyc;
  logic [32*KW-1:0] m_snap;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [32*KW-1:0] pack_key(int k);
    logic [32*KW-1:0] v = '0;
    for (int j = 0; j < KW; j++) v[32*(KW-1-j) +: 32] = m_key[k][j];
    return v;
  endfunction

  function automatic logic [32*BW-1:0] pack_blk(bit sel_st);
    logic [32*BW-1:0] v = '0;
    for (int i = 0; i < BW; i++) v[32*(BW-1-i) +: 32] = sel_st ? m_st[i] : m_pt[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < BW; i++) begin m_pt[i] = '0; m_st[i] = '0; m_ct[i] = '0; end
    for (int k = 0; k < NK; k++) for (int j = 0; j < KW; j++) m_key[k][j] = '0;
    m_ksel = '0; m_irq_en = 0; m_done = 0; m_to = 0; m_bad = 0; m_busy = 0; m_irq = 0;
    m_runcyc = 0; m_snap = '0;
  endfunction

  function automatic void model_resp(bit w, int a, logic [31:0] d, output logic [31:0] rd, output bit er);
    bit in_pt  = a >= 4 && a < P;
    bit in_st  = a >= P && a < A_CT;
    bit in_ct  = a >= A_CT && a < A_KS;
    bit in_key = a >= A_KEY && a < A_END;
    bit mapped = a == 0 || a == 1 || in_pt || in_st || in_ct || a == A_KS || in_key;
    rd = '0; er = 0;
    if (w) begin
      er = !mapped || a == 1 || in_ct
        || (a == 0 && (reglk[0] || reglk[6]))
        || ((in_pt || in_st) && reglk[3])
        || ((in_key || a == A_KS) && reglk[5])
        || (m_busy && (in_pt || in_st || in_key || a == A_KS || (a == 0 && (d[0] || d[1]))));
    end else begin
      if (a == 1 && !reglk[1]) rd = {28'd0, m_bad, m_to, m_done, m_busy};
      else if (in_pt && !reglk[2]) rd = m_pt[a-4];
      else if (in_st) rd = m_st[a-P];
      else if (in_ct && !reglk[4]) rd = m_ct[a-A_CT];
      else if (a == A_KS) rd = m_ksel;
    end
  endfunction

  function automatic void model_edge(bit acc, int a, logic [31:0] d, bit ev);
    if (acc && a == 0 && d[3]) begin m_done = 0; m_to = 0; m_bad = 0; end
    if (m_busy) begin
      if (ev) begin
        for (int i = 0; i < BW; i++) m_ct[i] = eng_ct[32*(BW-1-i) +: 32];
        m_done = 1; m_busy = 0;
      end else if (m_runcyc == TO - 1) begin
        m_to = 1; m_busy = 0;
      end else m_runcyc++;
    end
    if (acc) begin
      if (a >= 4 && a < P) m_pt[a-4] = d;
      else if (a >= P && a < A_CT) m_st[a-P] = d;
      else if (a == A_KS) m_ksel = d;
      else if (a >= A_KEY && a < A_END) m_key[(a-A_KEY)/KW][(a-A_KEY)%KW] = d;
      else if (a == 0) begin
        m_irq_en = d[2];
        if (d[1]) begin
          for (int k = 0; k < NK; k++) for (int j = 0; j < KW; j++) m_key[k][j] = '0;
          m_snap = '0;
        end else if (d[0]) begin
          if (m_ksel < NK) begin
            m_busy = 1; m_runcyc = 0; m_done = 0; m_to = 0; m_bad = 0;
            m_snap = pack_key(int'(m_ksel));
            start_q.push_back('{key: m_snap, pt: pack_blk(0), st: pack_blk(1)});
          end else m_bad = 1;
        end
      end
    end
    m_irq = m_irq_en && (m_done || m_to);
  endfunction

  task automatic cyc(bit v, bit w, int a, logic [31:0] d, bit ev);
    logic [31:0] rd;
    bit er;
    bus_valid = v; bus_write = w; bus_addr = 32'(a * 4); bus_wdata = d; eng_valid = ev;
    rd = '0; er = 0;
    if (v) begin
      model_resp(w, a, d, rd, er);
      resp_q.push_back('{rd: rd, er: er, a: a});
    end
    @(posedge clk); #1;
    model_edge(v && w && !er, a, d, ev);
    bus_valid = 0; bus_write = 0; eng_valid = 0;
  endtask

  task automatic wr(int a, logic [31:0] d); cyc(1, 1, a, d, 0); endtask
  task automatic rd(int a); cyc(1, 0, a, '0, 0); endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic rand_ct();
    for (int i = 0; i < BW; i++) eng_ct[32*i +: 32] = $urandom;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      start_t s;
      resp_t  r;
      chk("irq_o", 256'(irq), 256'(m_irq));
      chk("eng_key_o", 256'(eng_key), 256'(m_snap));
      chk("eng_pt_o", 256'(eng_pt), 256'(pack_blk(0)));
      chk("eng_state_o", 256'(eng_state), 256'(pack_blk(1)));
      if (eng_start) begin
        if (start_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL eng_start_o: got 1 expected 0 (no start pending)");
        end else begin
          s = start_q.pop_front();
          chk("start_key", 256'(eng_key), 256'(s.key));
          chk("start_pt", 256'(eng_pt), 256'(s.pt));
          chk("start_state", 256'(eng_state), 256'(s.st));
        end
      end else if (start_q.size() != 0) begin
        void'(start_q.pop_front());
        checks++; failures++;
        $display("FAIL eng_start_o: got 0 expected 1");
      end
      if (bus_valid) begin
        if (resp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL bus_resp: got request expected none queued");
        end else begin
          r = resp_q.pop_front();
          chk($sformatf("rdata[w%0d]", r.a), 256'(bus_rdata), 256'(r.rd));
          chk($sformatf("error[w%0d]", r.a), 256'(bus_error), 256'(r.er));
          chk("ready", 256'(bus_ready), 256'(1'b1));
        end
      end
    end
  end

  initial begin
    logic [31:0] pt_init [4];
    pt_init[0] = 32'h00112233; pt_init[1] = 32'h44556677;
    pt_init[2] = 32'h8899aabb; pt_init[3] = 32'hccddeeff;
    model_reset();
    @(posedge clk); #1;
    mon_on = 1;
    @(posedge clk); #1;
    rst_n = 1;

    // reset state
    rd(1); rd(4); rd(A_KS); rd(A_CT); rd(0); rd(2);

    // basic run with 12-cycle engine
    for (int i = 0; i < BW; i++) wr(4 + i, pt_init[i]);
    for (int i = 0; i < BW; i++) wr(P + i, $urandom);
    for (int j = 0; j < KW; j++) wr(A_KEY + j, $urandom);
    wr(A_KS, 0);
    rand_ct();
    wr(0, 32'h1);
    for (int i = 1; i <= 12; i++) cyc(1, 0, 1, '0, i == 12);
    rd(1);
    for (int i = 0; i < BW; i++) rd(A_CT + i);

    // lock gating
    reglk = 8'h28;
    wr(4, 32'hDEADBEEF); wr(A_KEY + KW, 32'h12345678); rd(4);
    reglk = 8'h10; rd(A_CT);
    reglk = 8'h02; rd(1);
    reglk = 8'h04; rd(4);
    reglk = 8'h00;
    wr(4, 32'hDEADBEEF); wr(A_KEY + KW, 32'h12345678); rd(4);
    wr(1, 32'h5); wr(2, 32'h5); wr(A_CT, 32'h5);

    // rejected writes while busy
    for (int j = 1; j < KW; j++) wr(A_KEY + KW + j, $urandom);
    wr(A_KS, 1);
    rand_ct();
    wr(0, 32'h1);
    wr(A_KS, 2); wr(0, 32'h1); wr(0, 32'h2); wr(4, 32'h0); wr(0, 32'h4);
    rd(A_KS); rd(1);
    for (int i = 1; i <= 5; i++) cyc(1, 0, 1, '0, i == 5);
    rd(A_KS);

    // timeout with interrupt
    wr(A_KS, 0);
    wr(0, 32'h5);
    for (int i = 1; i <= TO; i++) rd(1);
    rd(1);
    wr(0, 32'h8);
    rd(1);

    // completion beats a same-cycle clear
    rand_ct();
    wr(0, 32'h5);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, 0);
    cyc(1, 1, 0, 32'hC, 1);
    rd(1);

    // bad key select, zeroize, zero snapshot
    wr(0, 32'h8);
    wr(A_KS, 3);
    wr(0, 32'h1);
    rd(1);
    wr(0, 32'h3);
    rd(A_KEY); rd(A_KEY + 5);
    wr(A_KS, 0);
    wr(0, 32'h1);
    cyc(0, 0, 0, '0, 0);
    cyc(0, 0, 0, '0, 1);
    rd(1);

    // reset mid-run, late valid ignored
    rand_ct();
    wr(0, 32'h5);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, 0);
    do_reset();
    cyc(0, 0, 0, '0, 1);
    rd(1); rd(A_CT);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      int a;
      bit w;
      logic [31:0] d;
      a = $urandom_range(0, A_END + 2);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (a == 0) d = 32'($urandom_range(0, 15));
      if (a == A_KS) d = 32'($urandom_range(0, 4));
      reglk = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'h7F) : 8'h00;
      rand_ct();
      cyc(1, w, a, d, $urandom_range(0, 4) == 0);
    end
    reglk = 8'h00;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, 0);

    chk("resp_q_empty", 256'(resp_q.size()), 256'(0));
    chk("start_q_empty", 256'(start_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
